branch_flag_unit: RTL and testbench

Sequential program-counter and branch-resolution block for the single-cycle RISC core. It latches the `zero`/`sign` flags produced by the arithmetic unit, evaluates conditional-branch encodings against them, and owns the PC register. It also implements a two-state run/halt controller.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_cond_eval.sv | 26 ++
 rtl/branch_flag_unit.sv | 94 +++++++++
 tb/tb_branch_flag_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch/PC block: condition codes, run/halt state, PC step.
package branch_pkg;

    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_ALWAYS = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_NZ     = 3'b011;
    localparam logic [2:0] COND_S      = 3'b100;
    localparam logic [2:0] COND_POS    = 3'b101;
    localparam logic [2:0] COND_NS     = 3'b110;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition decode against a {sign, zero} flag pair.
// Code 3'b111 is reserved and falls through to never-taken.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       zero,
    input  logic       sign,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            COND_NEVER:  cond_true = 1'b0;
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = zero;
            COND_NZ:     cond_true = !zero;
            COND_S:      cond_true = sign;
            COND_POS:    cond_true = !sign && !zero;
            COND_NS:     cond_true = !sign;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flag_unit.sv
// PC register, flag latch, branch resolution and run/halt controller; all outputs registered.
// Optional macro BRANCH_FLAG_BYPASS_EN lets a same-cycle flag write feed the branch condition.
module branch_flag_unit
    import branch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              zero_in,
    input  logic              sign_in,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic              br_abs,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic [1:0]        flags_q,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_raw;
    logic              taken_q, taken_d;
    logic [1:0]        flags_d;
    logic              eval_zero, eval_sign, cond_true;

`ifdef BRANCH_FLAG_BYPASS_EN
    assign eval_zero = (flag_we && br_valid) ? zero_in : flags_q[0];
    assign eval_sign = (flag_we && br_valid) ? sign_in : flags_q[1];
`else
    assign eval_zero = flags_q[0];
    assign eval_sign = flags_q[1];
`endif

    branch_cond_eval u_cond (
        .cond      (br_cond),
        .zero      (eval_zero),
        .sign      (eval_sign),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d = state_q;
        pc_raw  = pc_q;
        taken_d = 1'b0;
        flags_d = flags_q;
        unique case (state_q)
            ST_RUN: begin
                if (flag_we) flags_d = {sign_in, zero_in};
                // A halt freezes the PC and swallows any branch in the same cycle.
                if (halt) begin
                    state_d = ST_HALT;
                end else if (br_valid && cond_true) begin
                    taken_d = 1'b1;
                    pc_raw  = br_abs ? br_target : pc_q + br_target;
                end else begin
                    pc_raw = pc_q + ADDR_W'(PC_STEP);
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                    pc_raw  = pc_q + ADDR_W'(PC_STEP);
                end
            end
            default: state_d = ST_RUN;
        endcase
        pc_d = {pc_raw[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            flags_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            flags_q <= flags_d;
        end
    end

    assign pc     = pc_q;
    assign taken  = taken_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed-vector bench for branch_flag_unit; expectations are hand-computed constants.
module tb_branch_flag_unit;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flag_we, zero_in, sign_in, br_valid, br_abs, halt, resume;
    logic [2:0]  br_cond;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        taken, halted;
    logic [1:0]  flags_q;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_pc;

    branch_flag_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .zero_in(zero_in), .sign_in(sign_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_abs(br_abs), .br_target(br_target),
        .halt(halt), .resume(resume), .pc(pc), .taken(taken), .flags_q(flags_q),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flag_we = 0; zero_in = 0; sign_in = 0; br_valid = 0;
        br_cond = COND_NEVER; br_abs = 0; br_target = '0; halt = 0; resume = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic branch(input logic [2:0] c, input logic a, input logic [31:0] t);
        br_valid = 1; br_cond = c; br_abs = a; br_target = t;
    endtask

    // Hand-derived truth masks indexed by condition code, one per {S,Z} flag pattern.
    logic [7:0] mask_tab [3] = '{8'b0110_1010, 8'b0100_0110, 8'b0001_1010};
    logic [1:0] flag_tab [3] = '{2'b00, 2'b01, 2'b10};

    initial begin
        // Reset state and free-running PC.
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_taken", {31'b0, taken}, 32'h0);
        chk("rst_flags", {30'b0, flags_q}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); chk("seq_pc12", pc, 32'hC);
        chk("seq_taken", {31'b0, taken}, 32'h0);

        // Flag write then BZ one cycle later.
        do_reset();
        tick();
        flag_we = 1; zero_in = 1;
        tick();
        chk("fw_pc", pc, 32'h8);
        chk("fw_flags", {30'b0, flags_q}, 32'h1);
        idle(); branch(COND_Z, 0, 32'h20);
        tick();
        chk("bz_pc", pc, 32'h28);
        chk("bz_taken", {31'b0, taken}, 32'h1);
        idle();
        tick();
        chk("bz_pc_next", pc, 32'h2C);
        chk("bz_taken_drop", {31'b0, taken}, 32'h0);

        // Same-cycle flag write and BZ with stale Z=0.
        do_reset();
        tick(); tick();
        flag_we = 1; zero_in = 1; branch(COND_Z, 0, 32'h20);
        tick();
`ifdef BRANCH_FLAG_BYPASS_EN
        chk("same_pc", pc, 32'h28);
        chk("same_taken", {31'b0, taken}, 32'h1);
`else
        chk("same_pc", pc, 32'hC);
        chk("same_taken", {31'b0, taken}, 32'h0);
`endif
        chk("same_flags", {30'b0, flags_q}, 32'h1);

        // Condition-code table across three flag patterns, relative offset 0x100.
        do_reset();
        exp_pc = 32'h0;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 8; c++) begin
                idle(); flag_we = 1; sign_in = flag_tab[f][1]; zero_in = flag_tab[f][0];
                tick();
                exp_pc = exp_pc + 32'h4;
                idle(); branch(3'(c), 0, 32'h100);
                tick();
                exp_pc = exp_pc + (mask_tab[f][c] ? 32'h100 : 32'h4);
                chk($sformatf("cc_taken_f%0d_c%0d", f, c), {31'b0, taken}, {31'b0, mask_tab[f][c]});
                chk($sformatf("cc_pc_f%0d_c%0d", f, c), pc, exp_pc);
            end
        end

        // Halt with a same-cycle always-branch at pc=16; halt ignores branch/flag/halt inputs.
        do_reset();
        tick(); tick(); tick(); tick();
        chk("pre_halt_pc", pc, 32'h10);
        halt = 1; branch(COND_ALWAYS, 1, 32'h80);
        tick();
        chk("halt_pc", pc, 32'h10);
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_taken", {31'b0, taken}, 32'h0);
        flag_we = 1; zero_in = 1; sign_in = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("halt_hold_pc%0d", i), pc, 32'h10);
            chk($sformatf("halt_hold_h%0d", i), {31'b0, halted}, 32'h1);
        end
        chk("halt_flags_ign", {30'b0, flags_q}, 32'h0);
        idle(); halt = 1; resume = 1;
        tick();
        chk("resume_pc", pc, 32'h14);
        chk("resume_halted", {31'b0, halted}, 32'h0);
        chk("resume_taken", {31'b0, taken}, 32'h0);
        idle(); resume = 1;
        tick();
        chk("run_resume_ign", pc, 32'h18);

        // Absolute alignment, negative offset and wrap-around.
        idle(); branch(COND_ALWAYS, 1, 32'h0000_0103);
        tick();
        chk("abs_align", pc, 32'h100);
        idle(); branch(COND_ALWAYS, 0, 32'hFFFF_FFF0);
        tick();
        chk("rel_neg", pc, 32'hF0);
        idle(); branch(COND_ALWAYS, 1, 32'hFFFF_FFFC);
        tick();
        chk("abs_top", pc, 32'hFFFF_FFFC);
        idle(); branch(COND_ALWAYS, 0, 32'h8);
        tick();
        chk("rel_wrap", pc, 32'h4);
        idle(); branch(COND_ALWAYS, 1, 32'hFFFF_FFFC);
        tick();
        idle();
        tick();
        chk("seq_wrap", pc, 32'h0);

        // Reset while halted, with branch, flag write and halt all asserted.
        idle(); flag_we = 1; zero_in = 1; sign_in = 1;
        tick();
        idle(); branch(COND_ALWAYS, 1, 32'h40);
        tick();
        chk("pre_rst_pc", pc, 32'h40);
        idle(); halt = 1;
        tick();
        chk("pre_rst_halted", {31'b0, halted}, 32'h1);
        chk("pre_rst_flags", {30'b0, flags_q}, 32'h3);
        rst = 1; halt = 1; resume = 1; flag_we = 1; zero_in = 1; branch(COND_ALWAYS, 1, 32'h80);
        tick();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_flags", {30'b0, flags_q}, 32'h0);
        chk("rst2_halted", {31'b0, halted}, 32'h0);
        chk("rst2_taken", {31'b0, taken}, 32'h0);
        idle();
        tick();
        chk("rst2_run", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
